// File: rtl/multi_scoreboard.sv
// Multi-channel event/sample scoreboard with freeze, sync clear, wrap/saturate counting
// and a snapshot that streams one channel per beat over a valid/ready port.
module multi_scoreboard #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CTR_WIDTH = 32,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        i_freeze,
  input  logic                                        i_clear,
  input  logic [NUM_CH-1:0]                           i_event,
  input  logic                                        i_snap,
  output logic                                        o_busy,
  output logic                                        o_valid,
  input  logic                                        i_ready,
  output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] o_ch,
  output logic [CTR_WIDTH-1:0]                        o_event_ctr,
  output logic [CTR_WIDTH-1:0]                        o_data_ctr,
  output logic                                        o_ovf,
  output logic                                        o_last
);

  localparam int unsigned          CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0]      LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] WRAP_VAL = SATURATE ? CTR_MAX : '0;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state_q, state_d;
  logic [CTR_WIDTH-1:0]   ev_ctr_q [NUM_CH];
  logic [CTR_WIDTH-1:0]   ev_ctr_d [NUM_CH];
  logic [NUM_CH-1:0]      ovf_q, ovf_d;
  logic [CTR_WIDTH-1:0]   data_ctr_q, data_ctr_d;
  logic                   ovf_data_q, ovf_data_d;
  logic [CTR_WIDTH-1:0]   sh_ev_q [NUM_CH];
  logic [CTR_WIDTH-1:0]   sh_ev_d [NUM_CH];
  logic [NUM_CH-1:0]      sh_ovf_q, sh_ovf_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [CTR_WIDTH-1:0]   ev_out_q, ev_out_d;
  logic [CTR_WIDTH-1:0]   data_out_q, data_out_d;
  logic                   ovf_out_q, ovf_out_d;
  logic                   last_q, last_d;

  logic [CTR_WIDTH:0]     data_bump;
  logic [CTR_WIDTH:0]     ev_bump [NUM_CH];

  // {overflow, next value} of a single increment under the configured overflow mode
  function automatic logic [CTR_WIDTH:0] bump(input logic [CTR_WIDTH-1:0] v);
    if (v == CTR_MAX) return {1'b1, WRAP_VAL};
    return {1'b0, v + CTR_WIDTH'(1)};
  endfunction

  assign data_bump = bump(data_ctr_q);
  for (genvar n = 0; n < NUM_CH; n++) begin : g_bump
    assign ev_bump[n] = bump(ev_ctr_q[n]);
  end

  // Live counters: clear beats freeze beats count
  always_comb begin
    data_ctr_d = data_ctr_q;
    ovf_data_d = ovf_data_q;
    ev_ctr_d   = ev_ctr_q;
    ovf_d      = ovf_q;
    if (i_clear) begin
      data_ctr_d = '0;
      ovf_data_d = 1'b0;
      ovf_d      = '0;
      for (int n = 0; n < NUM_CH; n++) ev_ctr_d[n] = '0;
    end else if (!i_freeze) begin
      data_ctr_d = data_bump[CTR_WIDTH-1:0];
      ovf_data_d = ovf_data_q | data_bump[CTR_WIDTH];
      for (int n = 0; n < NUM_CH; n++) begin
        if (i_event[n]) begin
          ev_ctr_d[n] = ev_bump[n][CTR_WIDTH-1:0];
          ovf_d[n]    = ovf_q[n] | ev_bump[n][CTR_WIDTH];
        end
      end
    end
  end

  // Snapshot / stream FSM; the first beat is loaded straight from the pre-edge live values
  always_comb begin
    state_d    = state_q;
    sh_ev_d    = sh_ev_q;
    sh_ovf_d   = sh_ovf_q;
    ch_d       = ch_q;
    ev_out_d   = ev_out_q;
    data_out_d = data_out_q;
    ovf_out_d  = ovf_out_q;
    last_d     = last_q;
    case (state_q)
      IDLE: begin
        if (i_snap) begin
          sh_ev_d    = ev_ctr_q;
          sh_ovf_d   = ovf_q | {NUM_CH{ovf_data_q}};
          ch_d       = '0;
          ev_out_d   = ev_ctr_q[0];
          data_out_d = data_ctr_q;
          ovf_out_d  = ovf_q[0] | ovf_data_q;
          last_d     = (NUM_CH == 1);
          state_d    = STREAM;
        end
      end
      STREAM: begin
        if (i_ready) begin
          if (last_q) begin
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            ch_d      = ch_q + CH_W'(1);
            ev_out_d  = sh_ev_q[ch_d];
            ovf_out_d = sh_ovf_q[ch_d];
            last_d    = (ch_d == LAST_CH);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_ctr_q <= '0;
      ovf_data_q <= 1'b0;
      ovf_q      <= '0;
      sh_ovf_q   <= '0;
      ch_q       <= '0;
      ev_out_q   <= '0;
      data_out_q <= '0;
      ovf_out_q  <= 1'b0;
      last_q     <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        ev_ctr_q[n] <= '0;
        sh_ev_q[n]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      data_ctr_q <= data_ctr_d;
      ovf_data_q <= ovf_data_d;
      ovf_q      <= ovf_d;
      sh_ovf_q   <= sh_ovf_d;
      ch_q       <= ch_d;
      ev_out_q   <= ev_out_d;
      data_out_q <= data_out_d;
      ovf_out_q  <= ovf_out_d;
      last_q     <= last_d;
      for (int n = 0; n < NUM_CH; n++) begin
        ev_ctr_q[n] <= ev_ctr_d[n];
        sh_ev_q[n]  <= sh_ev_d[n];
      end
    end
  end

  assign o_busy      = (state_q == STREAM);
  assign o_valid     = (state_q == STREAM);
  assign o_ch        = ch_q;
  assign o_event_ctr = ev_out_q;
  assign o_data_ctr  = data_out_q;
  assign o_ovf       = ovf_out_q;
  assign o_last      = last_q;

endmodule

// File: tb/tb_multi_scoreboard.sv
// Bench for multi_scoreboard: wrap and saturate 4-channel instances plus a 1-channel instance,
// checked against an unbounded-count reference model and a table of hand-derived vectors.
module tb_multi_scoreboard;

  localparam int NCH  = 4;
  localparam int MAXV = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_freeze, i_clear, i_snap, i_ready, snap1;
  logic [3:0] i_event;

  logic       w_busy, w_valid, w_ovf, w_last;
  logic [1:0] w_ch;
  logic [3:0] w_ev, w_data;
  logic       s_busy, s_valid, s_ovf, s_last;
  logic [1:0] s_ch;
  logic [3:0] s_ev, s_data;
  logic       u_busy, u_valid, u_ovf, u_last;
  logic [0:0] u_ch;
  logic [3:0] u_ev, u_data;

  always #5 clk = ~clk;

  multi_scoreboard #(.NUM_CH(4), .CTR_WIDTH(4), .SATURATE(1'b0)) dut_w (
    .clk(clk), .reset(reset), .i_freeze(i_freeze), .i_clear(i_clear), .i_event(i_event),
    .i_snap(i_snap), .o_busy(w_busy), .o_valid(w_valid), .i_ready(i_ready), .o_ch(w_ch),
    .o_event_ctr(w_ev), .o_data_ctr(w_data), .o_ovf(w_ovf), .o_last(w_last));

  multi_scoreboard #(.NUM_CH(4), .CTR_WIDTH(4), .SATURATE(1'b1)) dut_s (
    .clk(clk), .reset(reset), .i_freeze(i_freeze), .i_clear(i_clear), .i_event(i_event),
    .i_snap(i_snap), .o_busy(s_busy), .o_valid(s_valid), .i_ready(i_ready), .o_ch(s_ch),
    .o_event_ctr(s_ev), .o_data_ctr(s_data), .o_ovf(s_ovf), .o_last(s_last));

  multi_scoreboard #(.NUM_CH(1), .CTR_WIDTH(4), .SATURATE(1'b0)) dut_u (
    .clk(clk), .reset(reset), .i_freeze(i_freeze), .i_clear(i_clear), .i_event(i_event[0:0]),
    .i_snap(snap1), .o_busy(u_busy), .o_valid(u_valid), .i_ready(i_ready), .o_ch(u_ch),
    .o_event_ctr(u_ev), .o_data_ctr(u_data), .o_ovf(u_ovf), .o_last(u_last));

  // Reference model: true event/sample counts since the last clear; beats waiting to stream
  typedef struct { int ch; int ev; int data; bit ovf; } beat_t;
  beat_t q[$];
  beat_t hold;
  int    ev_cnt [NCH];
  int    data_cnt;
  int    total = 0;
  int    bad   = 0;

  typedef struct {
    logic [3:0]  pat;
    int          ncyc;
    logic [15:0] wev;
    int          wdata;
    logic [15:0] sev;
    int          sdata;
    logic [3:0]  ovf;
  } vec_t;
  vec_t vt [4];

  function automatic int wrapv(int c);
    return c % (MAXV + 1);
  endfunction

  function automatic int satv(int c);
    return (c > MAXV) ? MAXV : c;
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    hold     = '{0, 0, 0, 1'b0};
    data_cnt = 0;
    for (int n = 0; n < NCH; n++) ev_cnt[n] = 0;
  endtask

  task automatic model_update();
    beat_t b;
    if (q.size() != 0) begin
      if (i_ready) hold = q.pop_front();
    end else if (i_snap) begin
      for (int n = 0; n < NCH; n++) begin
        b.ch   = n;
        b.ev   = ev_cnt[n];
        b.data = data_cnt;
        b.ovf  = (ev_cnt[n] > MAXV) || (data_cnt > MAXV);
        q.push_back(b);
      end
    end
    if (i_clear) begin
      data_cnt = 0;
      for (int n = 0; n < NCH; n++) ev_cnt[n] = 0;
    end else if (!i_freeze) begin
      data_cnt++;
      for (int n = 0; n < NCH; n++) if (i_event[n]) ev_cnt[n]++;
    end
  endtask

  task automatic check_outputs();
    beat_t e;
    bit    v;
    v = (q.size() != 0);
    e = v ? q[0] : hold;
    chk("w_valid", int'(w_valid), int'(v));
    chk("w_busy",  int'(w_busy),  int'(v));
    chk("w_last",  int'(w_last),  int'(v && e.ch == NCH - 1));
    chk("w_ch",    int'(w_ch),    e.ch);
    chk("w_ev",    int'(w_ev),    wrapv(e.ev));
    chk("w_data",  int'(w_data),  wrapv(e.data));
    chk("w_ovf",   int'(w_ovf),   int'(e.ovf));
    chk("s_valid", int'(s_valid), int'(v));
    chk("s_last",  int'(s_last),  int'(v && e.ch == NCH - 1));
    chk("s_ch",    int'(s_ch),    e.ch);
    chk("s_ev",    int'(s_ev),    satv(e.ev));
    chk("s_data",  int'(s_data),  satv(e.data));
    chk("s_ovf",   int'(s_ovf),   int'(e.ovf));
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_inputs();
    i_freeze = 1'b0; i_clear = 1'b0; i_snap = 1'b0; snap1 = 1'b0; i_event = 4'b0000;
  endtask

  initial begin
    int   hs, prev_ev, prev_ch, rp [10];
    logic rdy;

    reset = 1'b1; i_ready = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    chk("rst_valid", int'(w_valid), 0);
    chk("rst_busy",  int'(w_busy),  0);
    chk("rst_ch",    int'(w_ch),    0);
    chk("rst_ev",    int'(w_ev),    0);
    chk("rst_data",  int'(w_data),  0);
    chk("rst_ovf",   int'(w_ovf),   0);
    chk("rst_last",  int'(w_last),  0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // Vectors: count N cycles of a fixed pattern from a clear, snapshot, stream with ready=1
    vt[0] = '{4'b0101, 10, 16'h0A0A, 10, 16'h0A0A, 10, 4'b0000};
    vt[1] = '{4'b0010, 17, 16'h0010,  1, 16'h00F0, 15, 4'b1111};
    vt[2] = '{4'b1111, 15, 16'hFFFF, 15, 16'hFFFF, 15, 4'b0000};
    vt[3] = '{4'b1000, 16, 16'h0000,  0, 16'hF000, 15, 4'b1111};
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); i_ready = 1'b0; i_clear = 1'b1;
      tick();
      i_clear = 1'b0; i_event = vt[i].pat;
      repeat (vt[i].ncyc) tick();
      i_event = 4'b0000; i_snap = 1'b1; snap1 = 1'b1;
      tick();
      i_snap = 1'b0; snap1 = 1'b0; i_ready = 1'b1;
      chk("v_u_valid", int'(u_valid), 1);
      chk("v_u_last",  int'(u_last),  1);
      chk("v_u_ch",    int'(u_ch),    0);
      chk("v_u_ev",    int'(u_ev),    int'(vt[i].wev[3:0]));
      chk("v_u_data",  int'(u_data),  vt[i].wdata);
      chk("v_u_ovf",   int'(u_ovf),   int'(vt[i].ovf[0]));
      for (int b = 0; b < NCH; b++) begin
        chk("v_w_ch",   int'(w_ch),   b);
        chk("v_w_ev",   int'(w_ev),   int'(vt[i].wev[b*4 +: 4]));
        chk("v_w_data", int'(w_data), vt[i].wdata);
        chk("v_w_ovf",  int'(w_ovf),  int'(vt[i].ovf[b]));
        chk("v_s_ev",   int'(s_ev),   int'(vt[i].sev[b*4 +: 4]));
        chk("v_s_data", int'(s_data), vt[i].sdata);
        chk("v_s_ovf",  int'(s_ovf),  int'(vt[i].ovf[b]));
        if (b == 1) chk("v_u_done", int'(u_valid), 0);
        tick();
      end
      chk("v_w_end", int'(w_valid), 0);
    end

    // Freeze for half the cycles, then clear and events on the same edge
    idle_inputs(); i_ready = 1'b0; i_clear = 1'b1;
    tick();
    i_clear = 1'b0; i_event = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      i_freeze = (k >= 5);
      tick();
    end
    idle_inputs(); i_snap = 1'b1;
    tick();
    i_snap = 1'b0; i_ready = 1'b1;
    chk("frz_ev0",  int'(w_ev),   5);
    chk("frz_data", int'(w_data), 5);
    repeat (NCH) tick();
    i_clear = 1'b1; i_event = 4'b1111;
    tick();
    idle_inputs(); i_snap = 1'b1;
    tick();
    i_snap = 1'b0;
    for (int b = 0; b < NCH; b++) begin
      chk("clr_ev",   int'(w_ev),   0);
      chk("clr_data", int'(w_data), 0);
      tick();
    end

    // Back-pressure with snap pulses during the stream
    rp = '{1, 0, 0, 1, 0, 1, 0, 0, 1, 1};
    idle_inputs(); i_event = 4'b0110; i_snap = 1'b1;
    tick();
    hs = 0;
    for (int k = 0; k < 40 && w_valid; k++) begin
      rdy     = rp[k % 10] != 0;
      i_ready = rdy;
      i_snap  = !rdy;
      prev_ev = int'(w_ev);
      prev_ch = int'(w_ch);
      if (w_valid && i_ready) hs++;
      tick();
      if (!rdy) begin
        chk("stall_ev", int'(w_ev), prev_ev);
        chk("stall_ch", int'(w_ch), prev_ch);
      end
    end
    chk("hs_count", hs, NCH);
    i_snap = 1'b0;
    tick();
    chk("no_queue", int'(w_valid), 0);

    // Snapshot and clear on the same edge; live counting continues through the stream
    idle_inputs(); i_ready = 1'b1; i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    repeat (7) tick();
    i_snap = 1'b1; i_clear = 1'b1;
    tick();
    i_snap = 1'b0; i_clear = 1'b0;
    chk("sc_data", int'(w_data), 7);
    repeat (NCH) tick();
    i_snap = 1'b1;
    tick();
    i_snap = 1'b0;
    chk("live_data", int'(w_data), 4);
    repeat (NCH) tick();

    // Reset after the second beat aborts the stream at once
    idle_inputs(); i_event = 4'b0011; i_snap = 1'b1; i_ready = 1'b1;
    tick();
    i_snap = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("ra_w_valid", int'(w_valid), 0);
    chk("ra_w_busy",  int'(w_busy),  0);
    chk("ra_s_valid", int'(s_valid), 0);
    chk("ra_w_ch",    int'(w_ch),    0);
    chk("ra_w_ev",    int'(w_ev),    0);
    chk("ra_w_data",  int'(w_data),  0);
    model_reset();
    idle_inputs();
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    i_snap = 1'b1;
    tick();
    i_snap = 1'b0;
    for (int b = 0; b < NCH; b++) begin
      chk("ra_beat_ch",   int'(w_ch),   b);
      chk("ra_beat_ev",   int'(w_ev),   0);
      chk("ra_beat_data", int'(w_data), 0);
      tick();
    end

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      i_event  = 4'($urandom);
      i_freeze = ($urandom_range(0, 3) == 0);
      i_clear  = ($urandom_range(0, 19) == 0);
      i_snap   = ($urandom_range(0, 7) == 0);
      i_ready  = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
